// File: rtl/ps2_key_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_key_scheduler                                                        |
// | Expands key events into paced PS/2 Set-2 bytes with typematic repeat.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_key_scheduler #(
  parameter int BYTE_GAP      = 128,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000,
  parameter int CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [7:0] ev_code,
  input  logic       ev_ext,
  input  logic       ev_release,
  input  logic       repeat_en,
  output logic       key_action,
  output logic [7:0] scan_code,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_E0   = 3'd1,
    SEND_F0   = 3'd2,
    SEND_CODE = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] GAP_MID = CNT_W'(BYTE_GAP - 2);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'(BYTE_GAP - 3);
  localparam logic [CNT_W-1:0] REP_DLY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_PER = CNT_W'(REPEAT_PERIOD);

  state_t           state, state_nxt;
  state_t           gap_next, gap_next_nxt;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] gap_limit;
  logic [CNT_W-1:0] rep_thresh;
  logic [7:0]       seq_code;
  logic             seq_rel;
  logic             held_valid;
  logic [7:0]       held_code;
  logic             held_ext;
  logic             after_rep;
  logic             accept;
  logic             rep_go;
  logic             launch;
  logic [7:0]       launch_code;
  logic             launch_ext;
  logic             launch_rel;
  logic             code_make_start;
  logic [7:0]       byte_nxt;
  logic             load_byte;

  function automatic state_t first_state(input logic ext, input logic rel);
    if (ext)      return SEND_E0;
    else if (rel) return SEND_F0;
    else          return SEND_CODE;
  endfunction

  assign ev_ready   = (state == IDLE) & ~reset;
  assign busy       = (state != IDLE);
  assign key_action = (state == SEND_E0) | (state == SEND_F0) | (state == SEND_CODE);

  // A host event always wins; a due repeat only launches on an idle cycle with no offer.
  assign accept      = ev_valid & ev_ready;
  assign rep_thresh  = after_rep ? REP_PER : REP_DLY;
  assign rep_go      = (state == IDLE) & ~ev_valid & held_valid & repeat_en &
                       (rep_cnt >= rep_thresh);
  assign launch      = accept | rep_go;
  assign launch_code = accept ? ev_code    : held_code;
  assign launch_ext  = accept ? ev_ext     : held_ext;
  assign launch_rel  = accept ? ev_release : 1'b0;
  assign gap_limit   = (gap_next == IDLE) ? GAP_END : GAP_MID;

  always_comb begin
    state_nxt    = state;
    gap_next_nxt = gap_next;
    case (state)
      IDLE: begin
        if (launch) state_nxt = first_state(launch_ext, launch_rel);
      end
      SEND_E0: begin
        state_nxt    = GAP;
        gap_next_nxt = seq_rel ? SEND_F0 : SEND_CODE;
      end
      SEND_F0: begin
        state_nxt    = GAP;
        gap_next_nxt = SEND_CODE;
      end
      SEND_CODE: begin
        // With the minimum gap the trailing wait is zero cycles long.
        state_nxt    = (BYTE_GAP > 2) ? GAP : IDLE;
        gap_next_nxt = IDLE;
      end
      GAP: begin
        if (gap_cnt == gap_limit) state_nxt = gap_next;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_byte = 1'b1;
    byte_nxt  = scan_code;
    case (state_nxt)
      SEND_E0:   byte_nxt = 8'hE0;
      SEND_F0:   byte_nxt = 8'hF0;
      SEND_CODE: byte_nxt = (state == IDLE) ? launch_code : seq_code;
      default:   load_byte = 1'b0;
    endcase
  end

  assign code_make_start = (state_nxt == SEND_CODE) &
                           ~((state == IDLE) ? launch_rel : seq_rel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gap_next  <= IDLE;
      gap_cnt   <= '0;
      scan_code <= 8'h00;
      seq_code  <= 8'h00;
      seq_rel   <= 1'b0;
    end else begin
      state    <= state_nxt;
      gap_next <= gap_next_nxt;
      gap_cnt  <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (load_byte) scan_code <= byte_nxt;
      if (state == IDLE && launch) begin
        seq_code <= launch_code;
        seq_rel  <= launch_rel;
      end
    end
  end

  // Held key tracking and the typematic timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_valid <= 1'b0;
      held_code  <= 8'h00;
      held_ext   <= 1'b0;
      rep_cnt    <= '0;
      after_rep  <= 1'b0;
    end else begin
      if (accept) begin
        if (!ev_release) begin
          held_valid <= 1'b1;
          held_code  <= ev_code;
          held_ext   <= ev_ext;
        end else if (held_valid && held_code == ev_code && held_ext == ev_ext) begin
          held_valid <= 1'b0;
        end
      end

      if (accept)      after_rep <= 1'b0;
      else if (rep_go) after_rep <= 1'b1;

      if (!held_valid || !repeat_en)        rep_cnt <= '0;
      else if (accept || code_make_start)   rep_cnt <= '0;
      else if (rep_cnt != {CNT_W{1'b1}})    rep_cnt <= rep_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
